// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared op codes, flag indices and FSM states for alu_datapath
// Purpose: single definition of the ALU op encoding, the flag bit positions
//          inside the 4-bit {V,N,C,Z} flag vector, and the controller states.
// Ports:   none (package).
package constants_pkg;

    localparam int ALU_OP_BITS = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [ALU_OP_BITS-1:0] {
        REG_READ  = 4'd0,
        REG_WRITE = 4'd1,
        ADD       = 4'd2,
        SUB       = 4'd3,
        ADC       = 4'd4,
        AND       = 4'd5,
        OR        = 4'd6,
        XOR       = 4'd7,
        SHL       = 4'd8,
        SHR       = 4'd9,
        CMP       = 4'd10,
        MUL       = 4'd11
    } alu_op_t;

    // State literals carry an S_ prefix so they cannot collide with the MUL op code.
    typedef enum logic {
        S_IDLE,
        S_MUL
    } alu_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - unsigned shift-add multiplier, one partial product per cycle
// Purpose: multiplies a by b over DATA_BITS cycles after the start edge.
// Ports:   clk, reset (async active-high), start (latch a/b, begin),
//          a, b (operands), product (full 2*DATA_BITS result, valid with done),
//          done (high in the cycle whose closing edge applies the final step).
module seq_multiplier #(
    parameter int DATA_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DATA_BITS-1:0]   a,
    input  logic [DATA_BITS-1:0]   b,
    output logic [2*DATA_BITS-1:0] product,
    output logic                   done
);

    localparam int CW = $clog2(DATA_BITS);

    logic                   running;
    logic [CW-1:0]          count;
    logic [2*DATA_BITS-1:0] mcand;
    logic [DATA_BITS-1:0]   mplier;
    logic [2*DATA_BITS-1:0] acc;
    logic [2*DATA_BITS-1:0] acc_next;

    // The product is exposed as the accumulator's next value so the consumer
    // can capture it on the very edge that applies the last step.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = running && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= CW'(DATA_BITS - 1);
            mcand   <= {{DATA_BITS{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - register file plus integer ALU with registered flags and multi-cycle multiply
// Purpose: executes one op per accepted handshake; single-cycle ops complete at
//          the accepting edge, MUL stalls op_ready for DATA_BITS cycles.
// Ports:   clk, reset (async active-high), op_valid/op_ready (handshake),
//          op, addr_a, addr_b, addr_r, data_in (op fields),
//          data_out/data_out_valid (REG_READ result), flags {V,N,C,Z}, busy.
module alu_datapath
    import constants_pkg::*;
#(
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [ALU_OP_BITS-1:0] op,
    input  logic [ADDR_BITS-1:0]   addr_a,
    input  logic [ADDR_BITS-1:0]   addr_b,
    input  logic [ADDR_BITS-1:0]   addr_r,
    input  logic [DATA_BITS-1:0]   data_in,
    output logic [DATA_BITS-1:0]   data_out,
    output logic                   data_out_valid,
    output logic [3:0]             flags,
    output logic                   busy
);

    localparam int NUM_REGS = 2 ** ADDR_BITS;
    localparam int MSB      = DATA_BITS - 1;

    logic [DATA_BITS-1:0]   regs [NUM_REGS];
    alu_state_t             state, state_next;
    logic [ADDR_BITS-1:0]   mul_dst;

    logic                   accept;
    logic [DATA_BITS-1:0]   ra, rb, b_op, res;
    logic                   cin, c_out, v_out;
    logic [DATA_BITS:0]     sum;
    logic                   is_sub;
    logic                   wr_en, flag_en, rd_en, mul_start;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [DATA_BITS-1:0]   wr_data;
    logic [2*DATA_BITS-1:0] product;
    logic                   mul_done;

    assign op_ready = (state == S_IDLE);
    assign busy     = !op_ready;
    assign accept   = op_valid && op_ready;
    assign ra       = regs[addr_a];
    assign rb       = regs[addr_b];

    // Subtraction is A + ~B + 1, so carry-out means "no borrow" and the
    // overflow test uses the inverted B exactly as the adder sees it.
    assign is_sub = (op == SUB) || (op == CMP);
    assign b_op   = is_sub ? ~rb : rb;
    assign cin    = is_sub ? 1'b1 : ((op == ADC) ? flags[FLAG_C] : 1'b0);
    assign sum    = {1'b0, ra} + {1'b0, b_op} + {{DATA_BITS{1'b0}}, cin};

    always_comb begin
        res       = '0;
        c_out     = 1'b0;
        v_out     = 1'b0;
        wr_en     = 1'b0;
        flag_en   = 1'b0;
        rd_en     = 1'b0;
        mul_start = 1'b0;
        wr_addr   = addr_r;
        wr_data   = '0;
        if (accept) begin
            case (op)
                REG_READ:  rd_en = 1'b1;
                REG_WRITE: begin
                    wr_en   = 1'b1;
                    wr_addr = addr_a;
                end
                ADD, ADC, SUB, CMP: begin
                    res     = sum[MSB:0];
                    c_out   = sum[DATA_BITS];
                    v_out   = (ra[MSB] == b_op[MSB]) && (sum[MSB] != ra[MSB]);
                    flag_en = 1'b1;
                    wr_en   = (op != CMP);
                end
                AND: begin res = ra & rb; flag_en = 1'b1; wr_en = 1'b1; end
                OR:  begin res = ra | rb; flag_en = 1'b1; wr_en = 1'b1; end
                XOR: begin res = ra ^ rb; flag_en = 1'b1; wr_en = 1'b1; end
                SHL: begin
                    res     = {ra[MSB-1:0], 1'b0};
                    c_out   = ra[MSB];
                    flag_en = 1'b1;
                    wr_en   = 1'b1;
                end
                SHR: begin
                    res     = {1'b0, ra[MSB:1]};
                    c_out   = ra[0];
                    flag_en = 1'b1;
                    wr_en   = 1'b1;
                end
                MUL:     mul_start = 1'b1;
                default: ;
            endcase
            wr_data = (op == REG_WRITE) ? data_in : res;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (mul_start) state_next = S_MUL;
            S_MUL:   if (mul_done)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    seq_multiplier #(.DATA_BITS(DATA_BITS)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (ra),
        .b       (rb),
        .product (product),
        .done    (mul_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            state          <= S_IDLE;
            mul_dst        <= '0;
            flags          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            state          <= state_next;
            data_out_valid <= rd_en;
            if (rd_en) begin
                data_out <= ra;
            end
            if (mul_start) begin
                mul_dst <= addr_r;
            end
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (flag_en) begin
                flags <= {v_out, res[MSB], c_out, (res == '0)};
            end
            // MUL completion never coincides with an accepted op: op_ready is low.
            if (state == S_MUL && mul_done) begin
                regs[mul_dst] <= product[MSB:0];
                flags <= {1'b0, product[MSB], (product[2*DATA_BITS-1:DATA_BITS] != '0),
                          (product[MSB:0] == '0)};
            end
        end
    end

endmodule

// File: tb/tb_alu_datapath.sv
// tb/tb_alu_datapath.sv - directed vector bench for alu_datapath
module tb_alu_datapath;
    import constants_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] op = 4'd0;
    logic [2:0] addr_a = 3'd0, addr_b = 3'd0, addr_r = 3'd0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [3:0] flags;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_datapath #(.ADDR_BITS(3), .DATA_BITS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op             (op),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .addr_r         (addr_r),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .flags          (flags),
        .busy           (busy)
    );

    typedef struct {
        logic [3:0] op;
        logic [2:0] a, b, r;
        logic [7:0] din;
        bit         chk;
        logic [7:0] exp_val;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] r, input logic [7:0] d);
        int waited;
        @(negedge clk);
        op = o; addr_a = a; addr_b = b; addr_r = r; data_in = d;
        op_valid = 1'b1;
        waited = 0;
        while (!op_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            check("op_ready_timeout", 32'(op_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, input logic [7:0] exp, input string name);
        do_op(REG_READ, a, 3'd0, 3'd0, 8'd0);
        check({name, "_valid"}, 32'(data_out_valid), 32'd1);
        check(name, 32'(data_out), 32'(exp));
    endtask

    initial begin
        logic [3:0] saved_flags;
        int low_cnt;

        // Table: ops applied in order; flags checked after each, destination read back when chk.
        vecs.push_back('{REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h7F, 1'b0, 8'h00, 4'b0000});
        vecs.push_back('{REG_WRITE, 3'd2, 3'd0, 3'd0, 8'h01, 1'b0, 8'h00, 4'b0000});
        vecs.push_back('{ADD,       3'd1, 3'd2, 3'd3, 8'h00, 1'b1, 8'h80, 4'b1100});
        vecs.push_back('{ADC,       3'd3, 3'd3, 3'd4, 8'h00, 1'b1, 8'h00, 4'b1011});
        vecs.push_back('{REG_WRITE, 3'd5, 3'd0, 3'd0, 8'h05, 1'b0, 8'h00, 4'b1011});
        vecs.push_back('{REG_WRITE, 3'd6, 3'd0, 3'd0, 8'h05, 1'b0, 8'h00, 4'b1011});
        vecs.push_back('{SUB,       3'd5, 3'd6, 3'd5, 8'h00, 1'b1, 8'h00, 4'b0011});
        vecs.push_back('{REG_WRITE, 3'd6, 3'd0, 3'd0, 8'h03, 1'b0, 8'h00, 4'b0011});
        vecs.push_back('{REG_WRITE, 3'd7, 3'd0, 3'd0, 8'h05, 1'b0, 8'h00, 4'b0011});
        vecs.push_back('{REG_WRITE, 3'd0, 3'd0, 3'd0, 8'h5A, 1'b0, 8'h00, 4'b0011});
        vecs.push_back('{CMP,       3'd6, 3'd7, 3'd0, 8'h00, 1'b1, 8'h5A, 4'b0100});
        vecs.push_back('{REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h81, 1'b0, 8'h00, 4'b0100});
        vecs.push_back('{SHL,       3'd1, 3'd0, 3'd2, 8'h00, 1'b1, 8'h02, 4'b0010});
        vecs.push_back('{REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h01, 1'b0, 8'h00, 4'b0010});
        vecs.push_back('{SHR,       3'd1, 3'd0, 3'd2, 8'h00, 1'b1, 8'h00, 4'b0011});
        vecs.push_back('{REG_WRITE, 3'd1, 3'd0, 3'd0, 8'hAA, 1'b0, 8'h00, 4'b0011});
        vecs.push_back('{XOR,       3'd1, 3'd1, 3'd3, 8'h00, 1'b1, 8'h00, 4'b0001});
        vecs.push_back('{REG_WRITE, 3'd2, 3'd0, 3'd0, 8'h0F, 1'b0, 8'h00, 4'b0001});
        vecs.push_back('{AND,       3'd1, 3'd2, 3'd4, 8'h00, 1'b1, 8'h0A, 4'b0000});
        vecs.push_back('{OR,        3'd1, 3'd2, 3'd4, 8'h00, 1'b1, 8'hAF, 4'b0100});
        vecs.push_back('{4'hF,      3'd1, 3'd2, 3'd4, 8'h00, 1'b1, 8'hAF, 4'b0100});
        vecs.push_back('{REG_WRITE, 3'd5, 3'd0, 3'd0, 8'h80, 1'b0, 8'h00, 4'b0100});
        vecs.push_back('{REG_WRITE, 3'd6, 3'd0, 3'd0, 8'h01, 1'b0, 8'h00, 4'b0100});
        vecs.push_back('{SUB,       3'd5, 3'd6, 3'd7, 8'h00, 1'b1, 8'h7F, 4'b1010});

        repeat (2) @(posedge clk);
        #1;
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_dvalid", 32'(data_out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), 8'h00, $sformatf("rst_read_r%0d", i));
            @(posedge clk);
            #1;
            check("dvalid_single_pulse", 32'(data_out_valid), 32'd0);
        end
        check("rst_read_flags", 32'(flags), 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].din);
            if (vecs[i].op != REG_READ) begin
                check($sformatf("vec%0d_no_pulse", i), 32'(data_out_valid), 32'd0);
            end
            check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
            if (vecs[i].chk) begin
                read_reg(vecs[i].r, vecs[i].exp_val, $sformatf("vec%0d_result", i));
                check($sformatf("vec%0d_read_keeps_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
            end
        end

        // MUL 0x10 * 0x11 = 0x0110, with a competing write held on op_valid while busy.
        do_op(REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h10);
        do_op(REG_WRITE, 3'd2, 3'd0, 3'd0, 8'h11);
        @(negedge clk);
        op = MUL; addr_a = 3'd1; addr_b = 3'd2; addr_r = 3'd1;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        check("mul_ready_low", 32'(op_ready), 32'd0);
        check("mul_busy", 32'(busy), 32'd1);
        op = REG_WRITE; addr_a = 3'd2; data_in = 8'hEE;
        low_cnt = 1;
        for (int i = 0; i < 20 && !op_ready; i++) begin
            @(posedge clk);
            #1;
            if (!op_ready) low_cnt++;
        end
        op_valid = 1'b0;
        check("mul_ready_low_cycles", 32'(low_cnt), 32'd8);
        check("mul_ready_back", 32'(op_ready), 32'd1);
        check("mul_flags", 32'(flags), 32'b0010);
        read_reg(3'd1, 8'h10, "mul_result");
        read_reg(3'd2, 8'h11, "mul_busy_write_ignored");

        // Reset during the 4th cycle of a multiply aborts it without a write.
        saved_flags = flags;
        check("pre_abort_flags", 32'(saved_flags), 32'b0010);
        @(negedge clk);
        op = MUL; addr_a = 3'd1; addr_b = 3'd2; addr_r = 3'd5;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_still_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_op_ready", 32'(op_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post_abort_ready", 32'(op_ready), 32'd1);
        check("post_abort_flags", 32'(flags), 32'd0);
        read_reg(3'd5, 8'h00, "abort_dst_zero");
        read_reg(3'd1, 8'h00, "abort_r1_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
